// File: rtl/icache_dm_param_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
//   state_e     : cache controller states
//   INSTR_W     : instruction / memory word width
//   width_min1  : address-field width that never collapses to zero bits
package icache_dm_param_pkg;

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Width of a field indexing n entries, at least 1 bit so single-entry fields stay legal.
  function automatic int unsigned width_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_dm_param_line_ram.sv
// Line data storage: LINES x LINE_WORDS x 32-bit words.
//   clk            : clock
//   i_we           : write enable for word (i_widx, i_woff)
//   i_widx/i_woff  : write line index / word offset
//   i_wdata        : write data
//   i_ridx/i_roff  : asynchronous read line index / word offset
//   o_rdata        : read data
module icache_dm_param_line_ram
  import icache_dm_param_pkg::*;
#(
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                                clk,
  input  logic                                i_we,
  input  logic [$clog2(LINES)-1:0]            i_widx,
  input  logic [width_min1(LINE_WORDS)-1:0]   i_woff,
  input  logic [INSTR_W-1:0]                  i_wdata,
  input  logic [$clog2(LINES)-1:0]            i_ridx,
  input  logic [width_min1(LINE_WORDS)-1:0]   i_roff,
  output logic [INSTR_W-1:0]                  o_rdata
);

  localparam int unsigned DEPTH = LINES * LINE_WORDS;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      w_waddr;
  logic [AW-1:0]      w_raddr;

  // Flat word address = line * LINE_WORDS + offset (offset is always 0 for 1-word lines).
  assign w_waddr = AW'(i_widx) * AW'(LINE_WORDS) + AW'(i_woff);
  assign w_raddr = AW'(i_ridx) * AW'(LINE_WORDS) + AW'(i_roff);

  always_ff @(posedge clk) begin
    if (i_we) r_mem[w_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[w_raddr];

endmodule

// File: rtl/icache_dm_param.sv
// Direct-mapped instruction cache between the fetch stage and mem_ctrl.
// Hits answer the cycle after the request; a miss refills the whole line word by
// word from word 0, then returns the requested word in a single RESP cycle.
//   clk, rst                   : clock, synchronous active-high reset
//   i_rdy                      : global ready; low freezes every register
//   i_if_req_valid, i_if_addr  : fetch request / byte address
//   o_if_ready                 : request can be accepted this cycle
//   i_if_abort                 : drop the outstanding response
//   o_if_resp_valid, o_if_instr: one-cycle response pulse / instruction
//   i_flush                    : invalidate all lines (fence.i)
//   o_mem_req_valid/_addr      : word request to mem_ctrl
//   i_mem_resp_valid/_data     : returned word for the current request
module icache_dm_param
  import icache_dm_param_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_rdy,
  input  logic               i_if_req_valid,
  input  logic [ADDR_W-1:0]  i_if_addr,
  output logic               o_if_ready,
  input  logic               i_if_abort,
  output logic               o_if_resp_valid,
  output logic [INSTR_W-1:0] o_if_instr,
  input  logic               i_flush,
  output logic               o_mem_req_valid,
  output logic [ADDR_W-1:0]  o_mem_req_addr,
  input  logic               i_mem_resp_valid,
  input  logic [INSTR_W-1:0] i_mem_resp_data
);

  localparam int unsigned OFF_W      = $clog2(LINE_WORDS);
  localparam int unsigned OFF_WS     = width_min1(LINE_WORDS);
  localparam int unsigned IDX_W      = $clog2(LINES);
  localparam int unsigned TAG_W      = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int unsigned LINE_BYTES = LINE_WORDS * 4;

  state_e             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [OFF_WS-1:0]  r_cnt;
  logic               r_poison;
  logic               r_drop;
  logic               r_resp_valid;
  logic [INSTR_W-1:0] r_instr;
  logic               r_if_ready;
  logic               r_mem_req_valid;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag [LINES];

  logic [OFF_WS-1:0]  w_req_off, w_lat_off, w_rd_off;
  logic [IDX_W-1:0]   w_req_idx, w_lat_idx, w_rd_idx;
  logic [TAG_W-1:0]   w_req_tag, w_lat_tag;
  logic               w_hit, w_last, w_we, w_fill_done;
  logic [INSTR_W-1:0] w_rdata;

  // Address fields of the incoming request and of the latched miss address.
  assign w_req_off = OFF_WS'((i_if_addr >> 2) & ADDR_W'(LINE_WORDS - 1));
  assign w_req_idx = IDX_W'(i_if_addr >> (2 + OFF_W));
  assign w_req_tag = TAG_W'(i_if_addr >> (2 + OFF_W + IDX_W));
  assign w_lat_off = OFF_WS'((r_addr >> 2) & ADDR_W'(LINE_WORDS - 1));
  assign w_lat_idx = IDX_W'(r_addr >> (2 + OFF_W));
  assign w_lat_tag = TAG_W'(r_addr >> (2 + OFF_W + IDX_W));

  assign w_hit       = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  assign w_last      = (r_cnt == OFF_WS'(LINE_WORDS - 1));
  assign w_we        = (r_state == ST_REFILL) && i_mem_resp_valid && i_rdy && !rst;
  assign w_fill_done = w_we && w_last;

  // IDLE reads for the hit lookup; otherwise the read port serves the latched miss word.
  assign w_rd_idx = (r_state == ST_IDLE) ? w_req_idx : w_lat_idx;
  assign w_rd_off = (r_state == ST_IDLE) ? w_req_off : w_lat_off;

  icache_dm_param_line_ram #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_line_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_widx  (w_lat_idx),
    .i_woff  (r_cnt),
    .i_wdata (i_mem_resp_data),
    .i_ridx  (w_rd_idx),
    .i_roff  (w_rd_off),
    .o_rdata (w_rdata)
  );

  // Tag store: written once the last word of a refill lands.
  always_ff @(posedge clk) begin
    if (w_fill_done) r_tag[w_lat_idx] <= w_lat_tag;
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_cnt           <= '0;
      r_poison        <= 1'b0;
      r_drop          <= 1'b0;
      r_resp_valid    <= 1'b0;
      r_instr         <= '0;
      r_if_ready      <= 1'b1;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= '0;
      r_valid         <= '0;
    end else if (i_rdy) begin
      r_resp_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_if_req_valid) begin
            if (w_hit) begin
              r_resp_valid <= 1'b1;
              r_instr      <= w_rdata;
            end else begin
              r_addr          <= i_if_addr;
              r_cnt           <= '0;
              r_mem_req_valid <= 1'b1;
              r_mem_addr      <= i_if_addr & ~ADDR_W'(LINE_BYTES - 1);
              r_if_ready      <= 1'b0;
              r_state         <= ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          if (i_if_abort) r_drop <= 1'b1;
          if (i_flush) r_poison <= 1'b1;
          if (i_mem_resp_valid) begin
            if (w_last) begin
              r_cnt           <= '0;
              r_mem_req_valid <= 1'b0;
              r_state         <= ST_RESP;
              if (!r_poison) r_valid[w_lat_idx] <= 1'b1;
              if (!r_drop && !i_if_abort) begin
                r_resp_valid <= 1'b1;
                // Requested word may be the one arriving right now.
                r_instr <= (r_cnt == w_lat_off) ? i_mem_resp_data : w_rdata;
              end
            end else begin
              r_cnt      <= r_cnt + OFF_WS'(1);
              r_mem_addr <= r_mem_addr + ADDR_W'(4);
            end
          end
        end
        ST_RESP: begin
          r_poison   <= 1'b0;
          r_drop     <= 1'b0;
          r_if_ready <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      // Flush overrides any same-edge validation.
      if (i_flush) r_valid <= '0;
    end
  end

  assign o_if_ready      = r_if_ready;
  assign o_if_instr      = r_instr;
  assign o_mem_req_valid = r_mem_req_valid;
  assign o_mem_req_addr  = r_mem_addr;
  // An abort in the cycle the pulse is shown cancels it (response cycle or hit cycle).
  assign o_if_resp_valid = r_resp_valid & ~(i_if_abort & i_rdy);

endmodule
